// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories.
interface mc_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic MemWrite;

    modport master (
        output imem_req,
        input  imem_ready,
        output dmem_req,
        input  dmem_ready,
        output MemWrite
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        input  dmem_req,
        output dmem_ready,
        input  MemWrite
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I controller: sequences IF/ID/EX/MEM/WB over a shared datapath,
// waits on req/ready memories with a bounded timeout, traps on illegal ops.
module mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       Op,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic             br_take,
    mc_ctrl_if.master        mem,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [2:0]       NPCOp,
    output logic             RegWrite,
    output logic [1:0]       WDSel,
    output logic             ALUSrc,
    output logic [5:0]       EXTOp,
    output logic [4:0]       ALUOp,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_TRAP = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [4:0] ALU_LUI  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_BNE  = 5'b00101;
    localparam logic [4:0] ALU_BLT  = 5'b00110;
    localparam logic [4:0] ALU_BGE  = 5'b00111;
    localparam logic [4:0] ALU_BLTU = 5'b01000;
    localparam logic [4:0] ALU_BGEU = 5'b01001;
    localparam logic [4:0] ALU_SLT  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;
    localparam logic [4:0] ALU_XOR  = 5'b01100;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01110;
    localparam logic [4:0] ALU_SLL  = 5'b01111;
    localparam logic [4:0] ALU_SRL  = 5'b10000;
    localparam logic [4:0] ALU_SRA  = 5'b10001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic       legal, is_br, is_jal, is_jalr, is_lw, is_sw;
    logic [4:0] alu_dec;
    logic [5:0] ext_dec;
    logic       alusrc_dec;
    logic       retire;
    logic       tmo_hit;

    // Shared R/I arithmetic table; alt selects sub/sra over add/srl.
    function automatic logic [4:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        legal      = 1'b0;
        is_br      = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        alu_dec    = '0;
        ext_dec    = '0;
        alusrc_dec = 1'b0;
        case (Op)
            OP_R: begin
                legal   = (Funct7 == 7'b0000000) ||
                          (Funct7 == 7'b0100000 && (Funct3 == 3'b000 || Funct3 == 3'b101));
                alu_dec = alu_fn(Funct3, Funct7[5]);
            end
            OP_I: begin
                if (Funct3 == 3'b001)      legal = (Funct7 == 7'b0000000);
                else if (Funct3 == 3'b101) legal = (Funct7 == 7'b0000000) || (Funct7 == 7'b0100000);
                else                       legal = 1'b1;
                alu_dec    = alu_fn(Funct3, Funct7[5] && Funct3 == 3'b101);
                ext_dec    = (Funct3 == 3'b001 || Funct3 == 3'b101) ? EXT_SHAMT : EXT_I;
                alusrc_dec = 1'b1;
            end
            OP_LOAD: begin
                legal      = (Funct3 == 3'b010);
                is_lw      = 1'b1;
                alu_dec    = ALU_ADD;
                ext_dec    = EXT_I;
                alusrc_dec = 1'b1;
            end
            OP_STORE: begin
                legal      = (Funct3 == 3'b010);
                is_sw      = 1'b1;
                alu_dec    = ALU_ADD;
                ext_dec    = EXT_S;
                alusrc_dec = 1'b1;
            end
            OP_BR: begin
                legal   = (Funct3[2:1] != 2'b01);
                is_br   = 1'b1;
                ext_dec = EXT_B;
                case (Funct3)
                    3'b000:  alu_dec = ALU_SUB;
                    3'b001:  alu_dec = ALU_BNE;
                    3'b100:  alu_dec = ALU_BLT;
                    3'b101:  alu_dec = ALU_BGE;
                    3'b110:  alu_dec = ALU_BLTU;
                    default: alu_dec = ALU_BGEU;
                endcase
            end
            OP_LUI: begin
                legal      = 1'b1;
                alu_dec    = ALU_LUI;
                ext_dec    = EXT_U;
                alusrc_dec = 1'b1;
            end
            OP_JAL: begin
                legal   = 1'b1;
                is_jal  = 1'b1;
                ext_dec = EXT_J;
            end
            OP_JALR: begin
                legal      = (Funct3 == 3'b000);
                is_jalr    = 1'b1;
                alu_dec    = ALU_ADD;
                ext_dec    = EXT_I;
                alusrc_dec = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // The limit is reached on the wait cycle that would bring the count to MEM_TIMEOUT.
    assign tmo_hit = (MEM_TIMEOUT != 0) && ((32'(tmo_q) + 32'd1) >= MEM_TIMEOUT);

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        tmo_d        = '0;
        retire       = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.MemWrite = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        NPCOp        = NPC_PLUS4;
        RegWrite     = 1'b0;
        WDSel        = 2'b00;
        ALUSrc       = 1'b0;
        EXTOp        = '0;
        ALUOp        = '0;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_ID;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_ID: begin
                if (legal) begin
                    state_d = S_EX;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_EX: begin
                ALUOp  = alu_dec;
                EXTOp  = ext_dec;
                ALUSrc = alusrc_dec;
                if (is_br) begin
                    PCWrite = br_take;
                    NPCOp   = NPC_BRANCH;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (is_jal) begin
                    PCWrite = 1'b1;
                    NPCOp   = NPC_JUMP;
                    state_d = S_WB;
                end else if (is_jalr) begin
                    PCWrite = 1'b1;
                    NPCOp   = NPC_JALR;
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.MemWrite = is_sw;
                if (mem.dmem_ready) begin
                    retire  = is_sw;
                    state_d = is_sw ? S_IF : S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b11;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (is_lw)                 WDSel = 2'b01;
                else if (is_jal || is_jalr) WDSel = 2'b10;
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cause_q   <= 2'b00;
            instret_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
            tmo_q     <= tmo_d;
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expectations are queued as each
// instruction is scheduled, then replayed against the DUT one cycle at a time.
module tb_mc_ctrl;

    localparam int TMO = 4;

    localparam int C_ALU  = 0;
    localparam int C_LW   = 1;
    localparam int C_SW   = 2;
    localparam int C_BR   = 3;
    localparam int C_JAL  = 4;
    localparam int C_JALR = 5;
    localparam int C_ILL  = 6;

    typedef struct {
        string       tag;
        logic [31:0] ir;
        logic        im_rdy, dm_rdy, br;
        logic [2:0]  st;
        logic        imreq, dmreq, mw, irw, pcw, rw;
        logic [2:0]  npc;
        logic [1:0]  wd;
        logic        trap;
        logic [1:0]  cause;
        logic        chk_alu;
        logic [4:0]  aluop;
        logic [5:0]  ext;
        logic        alusrc;
        logic        retire;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [6:0]  Op = '0;
    logic [6:0]  Funct7 = '0;
    logic [2:0]  Funct3 = '0;
    logic        br_take = 1'b0;
    logic        IRWrite, PCWrite, RegWrite, ALUSrc, trap;
    logic [2:0]  NPCOp, state;
    logic [1:0]  WDSel, trap_cause;
    logic [5:0]  EXTOp;
    logic [4:0]  ALUOp;
    logic [31:0] instret;

    mc_ctrl_if mif();

    mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .Op         (Op),
        .Funct7     (Funct7),
        .Funct3     (Funct3),
        .br_take    (br_take),
        .mem        (mif.master),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .NPCOp      (NPCOp),
        .RegWrite   (RegWrite),
        .WDSel      (WDSel),
        .ALUSrc     (ALUSrc),
        .EXTOp      (EXTOp),
        .ALUOp      (ALUOp),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret),
        .state      (state)
    );

    always #5 clk = ~clk;

    cyc_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_instret = '0;
    logic [31:0] cur_ir = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] strobes_now();
        return {mif.imem_req, mif.dmem_req, mif.MemWrite, IRWrite, PCWrite, RegWrite, NPCOp, WDSel};
    endfunction

    // Idle-looking cycle; ready/branch inputs carry noise the DUT must ignore.
    function automatic cyc_t base(input logic [2:0] st, input string tag);
        cyc_t c;
        c.tag = tag;    c.ir = cur_ir;  c.st = st;
        c.im_rdy = 1'($urandom); c.dm_rdy = 1'($urandom); c.br = 1'($urandom);
        c.imreq = 0; c.dmreq = 0; c.mw = 0; c.irw = 0; c.pcw = 0; c.rw = 0;
        c.npc = 3'b000; c.wd = 2'b00; c.trap = 0; c.cause = 2'b00;
        c.chk_alu = 0; c.aluop = '0; c.ext = '0; c.alusrc = 0; c.retire = 0;
        return c;
    endfunction

    task automatic push_trap(input string tag, input logic [1:0] cause);
        cyc_t c;
        for (int i = 0; i < 3; i++) begin
            c = base(3'd6, {tag, ".trap"});
            c.trap = 1'b1;
            c.cause = cause;
            sb.push_back(c);
        end
    endtask

    task automatic push_idle();
        sb.push_back(base(3'd0, "idle"));
    endtask

    task automatic add_instr(input string tag, input logic [31:0] ir, input int cls,
                             input logic [4:0] aluop, input logic [5:0] ext, input logic alusrc,
                             input int iw, input int dw, input logic br);
        cyc_t c;
        for (int i = 0; i < iw && i < TMO; i++) begin
            c = base(3'd1, {tag, ".ifw"});
            c.im_rdy = 1'b0;
            c.imreq = 1'b1;
            sb.push_back(c);
        end
        if (iw >= TMO) begin
            push_trap(tag, 2'b10);
            return;
        end
        c = base(3'd1, {tag, ".if"});
        c.im_rdy = 1'b1; c.imreq = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; c.npc = 3'b000;
        sb.push_back(c);
        cur_ir = ir;
        sb.push_back(base(3'd2, {tag, ".id"}));
        if (cls == C_ILL) begin
            push_trap(tag, 2'b01);
            return;
        end
        c = base(3'd3, {tag, ".ex"});
        c.chk_alu = (cls != C_JAL);
        c.aluop = aluop; c.ext = ext; c.alusrc = alusrc;
        c.br = br;
        if (cls == C_BR) begin
            c.pcw = br; c.npc = 3'b001; c.retire = 1'b1;
        end else if (cls == C_JAL) begin
            c.pcw = 1'b1; c.npc = 3'b010;
        end else if (cls == C_JALR) begin
            c.pcw = 1'b1; c.npc = 3'b100;
        end
        sb.push_back(c);
        if (cls == C_BR) return;
        if (cls == C_LW || cls == C_SW) begin
            for (int i = 0; i < dw && i < TMO; i++) begin
                c = base(3'd4, {tag, ".memw"});
                c.dm_rdy = 1'b0; c.dmreq = 1'b1; c.mw = (cls == C_SW);
                sb.push_back(c);
            end
            if (dw >= TMO) begin
                push_trap(tag, 2'b11);
                return;
            end
            c = base(3'd4, {tag, ".mem"});
            c.dm_rdy = 1'b1; c.dmreq = 1'b1; c.mw = (cls == C_SW); c.retire = (cls == C_SW);
            sb.push_back(c);
            if (cls == C_SW) return;
        end
        c = base(3'd5, {tag, ".wb"});
        c.rw = 1'b1; c.retire = 1'b1;
        c.wd = (cls == C_LW) ? 2'b01 : (cls == C_JAL || cls == C_JALR) ? 2'b10 : 2'b00;
        sb.push_back(c);
    endtask

    // Entered at posedge+1; each entry drives inputs, compares at negedge.
    task automatic drain();
        cyc_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            Op = e.ir[6:0]; Funct3 = e.ir[14:12]; Funct7 = e.ir[31:25];
            mif.imem_ready = e.im_rdy; mif.dmem_ready = e.dm_rdy; br_take = e.br;
            @(negedge clk);
            check({e.tag, ".state"}, 32'(state), 32'(e.st));
            check({e.tag, ".strobes"}, 32'(strobes_now()),
                  32'({e.imreq, e.dmreq, e.mw, e.irw, e.pcw, e.rw, e.npc, e.wd}));
            check({e.tag, ".trap"}, 32'({trap, trap_cause}), 32'({e.trap, e.cause}));
            check({e.tag, ".instret"}, instret, exp_instret);
            if (e.chk_alu)
                check({e.tag, ".alu"}, 32'({ALUOp, EXTOp, ALUSrc}), 32'({e.aluop, e.ext, e.alusrc}));
            if (e.retire) exp_instret = exp_instret + 32'd1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        #2 rstn = 1'b0;
        #1;
        check({tag, ".rst_state"}, 32'(state), 32'd0);
        check({tag, ".rst_strobes"}, 32'({strobes_now(), ALUOp, EXTOp, ALUSrc}), 32'd0);
        check({tag, ".rst_trap"}, 32'({trap, trap_cause}), 32'd0);
        check({tag, ".rst_instret"}, instret, 32'd0);
        exp_instret = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    logic [31:0] illegal_ops [5] = '{32'h0000007F, 32'h000110E7, 32'h402091B3,
                                     32'h00208223, 32'h0020A463};

    initial begin
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        do_reset("init");

        push_idle();
        add_instr("add",  32'h002081B3, C_ALU, 5'b00011, 6'b000000, 1'b0, 0, 0, 1'b0);
        add_instr("sub",  32'h402081B3, C_ALU, 5'b00100, 6'b000000, 1'b0, 0, 0, 1'b0);
        add_instr("sra",  32'h4020D1B3, C_ALU, 5'b10001, 6'b000000, 1'b0, 0, 0, 1'b0);
        add_instr("sltu", 32'h0020B1B3, C_ALU, 5'b01011, 6'b000000, 1'b0, 0, 0, 1'b0);
        add_instr("addi", 32'h00500093, C_ALU, 5'b00011, 6'b010000, 1'b1, 1, 0, 1'b0);
        add_instr("srai", 32'h4030D093, C_ALU, 5'b10001, 6'b100000, 1'b1, 0, 0, 1'b0);
        add_instr("andi", 32'h0FF0F093, C_ALU, 5'b01110, 6'b010000, 1'b1, 0, 0, 1'b0);
        add_instr("lui",  32'h123452B7, C_ALU, 5'b00001, 6'b000010, 1'b1, TMO - 1, 0, 1'b0);
        add_instr("lw",   32'h0000A183, C_LW,  5'b00011, 6'b010000, 1'b1, 0, 3, 1'b0);
        add_instr("sw",   32'h0020A223, C_SW,  5'b00011, 6'b001000, 1'b1, 2, 1, 1'b0);
        add_instr("lw0",  32'h0000A183, C_LW,  5'b00011, 6'b010000, 1'b1, 0, 0, 1'b0);
        add_instr("beqT", 32'h00208463, C_BR,  5'b00100, 6'b000100, 1'b0, 0, 0, 1'b1);
        add_instr("beqN", 32'h00208463, C_BR,  5'b00100, 6'b000100, 1'b0, 0, 0, 1'b0);
        add_instr("bne",  32'h00209463, C_BR,  5'b00101, 6'b000100, 1'b0, 0, 0, 1'b1);
        add_instr("bgeu", 32'h0020F463, C_BR,  5'b01001, 6'b000100, 1'b0, 0, 0, 1'b0);
        add_instr("jal",  32'h008000EF, C_JAL, 5'b00000, 6'b000001, 1'b0, 0, 0, 1'b0);
        add_instr("jalr", 32'h000100E7, C_JALR,5'b00011, 6'b010000, 1'b1, 0, 0, 1'b0);
        drain();

        // Reset lands while the aborted instruction sits in EX.
        add_instr("abort", 32'h002081B3, C_ALU, 5'b00011, 6'b000000, 1'b0, 0, 0, 1'b0);
        void'(sb.pop_back());
        void'(sb.pop_back());
        drain();
        do_reset("abort");

        foreach (illegal_ops[k]) begin
            push_idle();
            add_instr("add_pre", 32'h002081B3, C_ALU, 5'b00011, 6'b000000, 1'b0, 0, 0, 1'b0);
            add_instr($sformatf("ill%0d", k), illegal_ops[k], C_ILL, '0, '0, 1'b0, 0, 0, 1'b0);
            drain();
            do_reset($sformatf("ill%0d", k));
        end

        push_idle();
        add_instr("itmo", 32'h002081B3, C_ALU, 5'b00011, 6'b000000, 1'b0, TMO, 0, 1'b0);
        drain();
        do_reset("itmo");

        push_idle();
        add_instr("dtmo", 32'h0000A183, C_LW, 5'b00011, 6'b010000, 1'b1, 0, TMO, 1'b0);
        drain();
        do_reset("dtmo");

        push_idle();
        add_instr("post", 32'h00500093, C_ALU, 5'b00011, 6'b010000, 1'b1, 0, 0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
